dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
- Data-memory responder on the far side of the MEM-stage load/store interface: the MEM stage issues requests, this block services them.
- Accepts one request at a time through a valid/ready handshake and models fixed access latency. Returns one response pulse per request.
- Performs RV32I byte/halfword/word lane handling, load sign/zero extension, and misalignment/range checking.
- Drives a stall signal back to the pipeline while a request is outstanding.

Parameters:
- DEPTH_WORDS, 256, number of 32-bit words of storage; word index is addr[31:2].
- LATENCY, 2, cycles from request acceptance to response; legal range 1..15.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  1  request present.
- req_write  input  1  1=store, 0=load.
- req_funct3  input  3  RV32I funct3: LB=0, LH=1, LW=2, LBU=4, LHU=5; SB=0, SH=1, SW=2.
- req_addr  input  32  byte address.
- req_wdata  input  32  store data; low bytes are used for SB/SH.
- req_ready  output  1  high only in IDLE.
- resp_valid  output  1  one-cycle response pulse.
- resp_rdata  output  32  extended load data; 0 for stores and errors.
- resp_err  output  1  qualifies resp_valid; misaligned, illegal funct3, or out of range.
- stall  output  1  pipeline hold request.

Behaviour:
- Reset (synchronous, active-high): state=IDLE; req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, stall=0; counter=0.
- Reset does not clear the storage array. The array is zero-initialised at time 0 for simulation.
- Reset mid-operation: the pending request is dropped and no write occurs.
- FSM states: IDLE, BUSY, RESP.
- IDLE:
  - If req_valid is high at edge T, latch write, funct3, addr, and wdata; compute err; load counter=LATENCY-1.
  - Next state is BUSY if LATENCY>1, else RESP.
- BUSY:
  - Decrement counter each cycle. When counter reaches 0, transition to RESP.
  - req_* inputs are ignored.
- Edge entering RESP:
  - If no err and store: write byte lanes. SB writes lane addr[1:0]. SH writes lanes {addr[1],0} and {addr[1],1}. SW writes all four lanes. Little-endian.
  - If no err and load: register the extended data.
  - If err: no write, rdata=0.
- RESP:
  - resp_valid=1 for exactly one cycle, at T+LATENCY after acceptance.
  - resp_err valid in the same cycle.
  - Next state is IDLE.
  - resp_rdata holds its value until the next response.
- Maximum throughput: one request per LATENCY+1 cycles. Next acceptance is possible in the cycle after RESP.
- Error conditions:
  - LH/LHU/SH with addr[0]=1.
  - LW/SW with addr[1:0]!=0.
  - Load funct3 in {3,6,7}.
  - Store funct3 >2.
  - addr[31:2] >= DEPTH_WORDS.
- Load extension:
  - LB sign-extends bit 7 of the selected byte; LBU zero-extends.
  - LH sign-extends bit 15 of the selected halfword; LHU zero-extends.
- stall = (state==BUSY) | (state==IDLE & req_valid). stall=0 during RESP, so the pipeline advances in the response cycle.
- Simultaneous events: rst has priority over everything. A req_valid held high through RESP is accepted again in IDLE; the initiator must drop it.

Test Plan:
- SW 100 to 0x8, then LW 0x8 (LATENCY=2) -> resp_valid 2 cycles after each acceptance; rdata=100; err=0; stall high for 2 cycles per request.
- SW 0x8000_00F0 to 0x10; LB 0x10 -> 0xFFFF_FFF0; LBU 0x13 -> 0x0000_0080; LH 0x12 -> 0xFFFF_8000; LHU 0x10 -> 0x0000_00F0.
- SB 0xAB to 0x15 over word 0 at 0x14, then LW 0x14 -> 0x0000_AB00. SH 0x1234 to 0x16, then LW 0x14 -> 0x1234_AB00.
- LW 0x9, SH 0x11, load funct3=3, and SW 0x400 (DEPTH_WORDS=256) -> each gives resp_err=1, rdata=0, and memory unchanged on readback.
- rst asserted in BUSY during SW 55 to 0x20 -> next cycle IDLE, resp_valid never pulses; LW 0x20 returns its prior value 0.
- LATENCY=1 sweep plus back-to-back req_valid held high -> responses every 2 cycles; req_ready low in RESP; no request lost or duplicated beyond the one-per-IDLE rule.

Source files
------------

// File: rtl/dmem_responder.sv
// Data-memory responder: services one MEM-stage load/store at a time with RV32I lane handling.
// Latency: response pulse LATENCY cycles after acceptance; one request per LATENCY+1 cycles.
// Backpressure: req_ready only in IDLE; stall holds the pipeline until the response cycle.
module dmem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        req_ready,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        stall
);

  localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  typedef struct packed {
    logic        write;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        err;
  } req_t;

  state_t      state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  req_t        held, cur;
  logic        enter_resp;
  logic        do_write;
  logic [IDX_W-1:0] widx;
  logic [31:0] rd_word;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;
  logic [31:0] load_data;
  logic [3:0]  be;
  logic [31:0] lanes;

  // Storage is deliberately outside reset; zero at time 0 for simulation.
  logic [31:0] mem [DEPTH_WORDS] = '{default: '0};

  function automatic logic req_error(input logic w, input logic [2:0] f3, input logic [31:0] a);
    logic bad;
    if (w) begin
      case (f3)
        3'd0:    bad = 1'b0;
        3'd1:    bad = a[0];
        3'd2:    bad = |a[1:0];
        default: bad = 1'b1;
      endcase
    end else begin
      case (f3)
        3'd0, 3'd4: bad = 1'b0;
        3'd1, 3'd5: bad = a[0];
        3'd2:       bad = |a[1:0];
        default:    bad = 1'b1;
      endcase
    end
    return bad | (a[31:2] >= 30'(DEPTH_WORDS));
  endfunction

  // With LATENCY=1 the access happens on the acceptance edge, so IDLE uses the live request.
  always_comb begin
    cur = held;
    if (state == IDLE) begin
      cur.write  = req_write;
      cur.funct3 = req_funct3;
      cur.addr   = req_addr;
      cur.wdata  = req_wdata;
      cur.err    = req_error(req_write, req_funct3, req_addr);
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (req_valid) begin
          cnt_nxt   = 4'(LATENCY - 1);
          state_nxt = (LATENCY > 1) ? BUSY : RESP;
        end
      end
      BUSY: begin
        cnt_nxt = cnt - 4'd1;
        if (cnt <= 4'd1) state_nxt = RESP;
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign req_ready  = (state == IDLE);
  assign resp_valid = (state == RESP);
  assign stall      = (state == BUSY) | ((state == IDLE) & req_valid);
  assign enter_resp = (state_nxt == RESP);

  assign widx    = cur.addr[IDX_W+1:2];
  assign rd_word = mem[widx];
  assign rd_byte = rd_word[{cur.addr[1:0], 3'b000} +: 8];
  assign rd_half = cur.addr[1] ? rd_word[31:16] : rd_word[15:0];

  always_comb begin
    load_data = '0;
    case (cur.funct3)
      3'd0:    load_data = {{24{rd_byte[7]}}, rd_byte};
      3'd4:    load_data = {24'b0, rd_byte};
      3'd1:    load_data = {{16{rd_half[15]}}, rd_half};
      3'd5:    load_data = {16'b0, rd_half};
      3'd2:    load_data = rd_word;
      default: load_data = '0;
    endcase
  end

  // Store data is replicated across lanes; the byte enables pick the little-endian target.
  always_comb begin
    be    = 4'b0000;
    lanes = cur.wdata;
    case (cur.funct3)
      3'd0: begin
        be    = 4'b0001 << cur.addr[1:0];
        lanes = {4{cur.wdata[7:0]}};
      end
      3'd1: begin
        be    = cur.addr[1] ? 4'b1100 : 4'b0011;
        lanes = {2{cur.wdata[15:0]}};
      end
      3'd2:    be = 4'b1111;
      default: be = 4'b0000;
    endcase
  end

  assign do_write = enter_resp & cur.write & ~cur.err & ~rst;

  always_ff @(posedge clk) begin
    if (do_write) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[widx][8*i +: 8] <= lanes[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      held       <= '0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if ((state == IDLE) && req_valid) held <= cur;
      if (enter_resp) begin
        resp_err   <= cur.err;
        resp_rdata <= (cur.err | cur.write) ? 32'd0 : load_data;
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: LATENCY=2 instance for function/errors/reset,
// LATENCY=1 instance for back-to-back throughput with req_valid held high.
module tb_dmem_responder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        a_req_valid = 1'b0, a_req_write = 1'b0;
  logic [2:0]  a_req_funct3 = '0;
  logic [31:0] a_req_addr = '0, a_req_wdata = '0;
  logic        a_req_ready, a_resp_valid, a_resp_err, a_stall;
  logic [31:0] a_resp_rdata;

  logic        b_req_valid = 1'b0, b_req_write = 1'b0;
  logic [2:0]  b_req_funct3 = '0;
  logic [31:0] b_req_addr = '0, b_req_wdata = '0;
  logic        b_req_ready, b_resp_valid, b_resp_err, b_stall;
  logic [31:0] b_resp_rdata;

  dmem_responder #(.DEPTH_WORDS(256), .LATENCY(2)) dut_a (
    .clk(clk), .rst(rst),
    .req_valid(a_req_valid), .req_write(a_req_write), .req_funct3(a_req_funct3),
    .req_addr(a_req_addr), .req_wdata(a_req_wdata), .req_ready(a_req_ready),
    .resp_valid(a_resp_valid), .resp_rdata(a_resp_rdata), .resp_err(a_resp_err),
    .stall(a_stall)
  );

  dmem_responder #(.DEPTH_WORDS(256), .LATENCY(1)) dut_b (
    .clk(clk), .rst(rst),
    .req_valid(b_req_valid), .req_write(b_req_write), .req_funct3(b_req_funct3),
    .req_addr(b_req_addr), .req_wdata(b_req_wdata), .req_ready(b_req_ready),
    .resp_valid(b_resp_valid), .resp_rdata(b_resp_rdata), .resp_err(b_resp_err),
    .stall(b_stall)
  );

  int n_cmp = 0;
  int n_err = 0;
  logic [32:0] sb_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One LATENCY=2 transaction: push expectation, drive, wait for the pulse, pop and compare.
  task automatic xact(input string tag, input logic w, input logic [2:0] f3,
                      input logic [31:0] a, input logic [31:0] wd,
                      input logic [31:0] er, input logic ee);
    int n;
    int st;
    logic [32:0] e;
    sb_q.push_back({ee, er});
    chk({tag, ".ready_idle"}, {31'b0, a_req_ready}, 32'd1);
    a_req_valid = 1'b1; a_req_write = w; a_req_funct3 = f3;
    a_req_addr = a; a_req_wdata = wd;
    #1;
    st = a_stall ? 1 : 0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (n == 1) a_req_valid = 1'b0;
      #1;
      if (!a_resp_valid && a_stall) st++;
    end while (!a_resp_valid && n < 20);
    chk({tag, ".latency"}, n, 2);
    chk({tag, ".stall_cycles"}, st, 2);
    chk({tag, ".stall_resp"}, {31'b0, a_stall}, 32'd0);
    chk({tag, ".ready_resp"}, {31'b0, a_req_ready}, 32'd0);
    e = sb_q.pop_front();
    chk({tag, ".rdata"}, a_resp_rdata, e[31:0]);
    chk({tag, ".err"}, {31'b0, a_resp_err}, {31'b0, e[32]});
    @(negedge clk);
    chk({tag, ".rdata_hold"}, a_resp_rdata, e[31:0]);
  endtask

  initial begin
    int resp_cnt;
    int k;
    logic [32:0] e;

    repeat (3) @(negedge clk);
    chk("rst.ready", {31'b0, a_req_ready}, 32'd1);
    chk("rst.resp_valid", {31'b0, a_resp_valid}, 32'd0);
    chk("rst.rdata", a_resp_rdata, 32'd0);
    chk("rst.err", {31'b0, a_resp_err}, 32'd0);
    chk("rst.stall", {31'b0, a_stall}, 32'd0);
    chk("rst.b_ready", {31'b0, b_req_ready}, 32'd1);
    rst = 1'b0;
    @(negedge clk);

    xact("sw8",    1'b1, 3'd2, 32'h8,  32'd100,        32'd0,          1'b0);
    xact("lw8",    1'b0, 3'd2, 32'h8,  32'd0,          32'd100,        1'b0);
    xact("sw10",   1'b1, 3'd2, 32'h10, 32'h8000_00F0,  32'd0,          1'b0);
    xact("lb10",   1'b0, 3'd0, 32'h10, 32'd0,          32'hFFFF_FFF0,  1'b0);
    xact("lbu13",  1'b0, 3'd4, 32'h13, 32'd0,          32'h0000_0080,  1'b0);
    xact("lh12",   1'b0, 3'd1, 32'h12, 32'd0,          32'hFFFF_8000,  1'b0);
    xact("lhu10",  1'b0, 3'd5, 32'h10, 32'd0,          32'h0000_00F0,  1'b0);
    xact("sb15",   1'b1, 3'd0, 32'h15, 32'h0000_00AB,  32'd0,          1'b0);
    xact("lw14a",  1'b0, 3'd2, 32'h14, 32'd0,          32'h0000_AB00,  1'b0);
    xact("sh16",   1'b1, 3'd1, 32'h16, 32'h0000_1234,  32'd0,          1'b0);
    xact("lw14b",  1'b0, 3'd2, 32'h14, 32'd0,          32'h1234_AB00,  1'b0);

    xact("e_lw9",  1'b0, 3'd2, 32'h9,  32'd0,          32'd0,          1'b1);
    xact("e_sh11", 1'b1, 3'd1, 32'h11, 32'h0000_5555,  32'd0,          1'b1);
    xact("e_ld3",  1'b0, 3'd3, 32'h10, 32'd0,          32'd0,          1'b1);
    xact("e_sw400",1'b1, 3'd2, 32'h400,32'hDEAD_BEEF,  32'd0,          1'b1);
    xact("e_sw12", 1'b1, 3'd2, 32'h12, 32'hDEAD_BEEF,  32'd0,          1'b1);
    xact("e_st3",  1'b1, 3'd3, 32'h10, 32'hDEAD_BEEF,  32'd0,          1'b1);
    xact("e_lb400",1'b0, 3'd0, 32'h400,32'd0,          32'd0,          1'b1);
    xact("rb10",   1'b0, 3'd2, 32'h10, 32'd0,          32'h8000_00F0,  1'b0);
    xact("rb0",    1'b0, 3'd2, 32'h0,  32'd0,          32'd0,          1'b0);

    // Reset while BUSY: request dropped, no write, no response pulse.
    a_req_valid = 1'b1; a_req_write = 1'b1; a_req_funct3 = 3'd2;
    a_req_addr = 32'h20; a_req_wdata = 32'd55;
    @(negedge clk);
    chk("rstmid.busy_stall", {31'b0, a_stall}, 32'd1);
    a_req_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("rstmid.ready", {31'b0, a_req_ready}, 32'd1);
    chk("rstmid.stall", {31'b0, a_stall}, 32'd0);
    chk("rstmid.resp_valid", {31'b0, a_resp_valid}, 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rstmid.no_pulse", {31'b0, a_resp_valid}, 32'd0);
    end
    xact("lw20",   1'b0, 3'd2, 32'h20, 32'd0,          32'd0,          1'b0);

    // LATENCY=1 with req_valid held high: accept on even cycles, respond on odd ones.
    resp_cnt = 0;
    k = 0;
    b_req_valid = 1'b1;
    for (int c = 0; c < 13; c++) begin
      chk("b.resp_pattern", {31'b0, b_resp_valid}, {31'b0, c[0]});
      chk("b.ready_pattern", {31'b0, b_req_ready}, {31'b0, ~c[0]});
      if (b_resp_valid) begin
        resp_cnt++;
        if (sb_q.size() == 0) begin
          chk("b.unexpected_resp", 32'd1, 32'd0);
        end else begin
          e = sb_q.pop_front();
          chk("b.rdata", b_resp_rdata, e[31:0]);
          chk("b.err", {31'b0, b_resp_err}, {31'b0, e[32]});
        end
      end
      if (b_req_ready) begin
        if (k < 6) begin
          b_req_write  = (k < 3);
          b_req_funct3 = 3'd2;
          b_req_addr   = 32'(4 * (k % 3));
          b_req_wdata  = 32'(3 * (k % 3) + 1);
          sb_q.push_back({1'b0, (k < 3) ? 32'd0 : 32'(3 * (k % 3) + 1)});
          k++;
        end else begin
          b_req_valid = 1'b0;
        end
      end
      #1;
      chk("b.stall", {31'b0, b_stall}, {31'b0, b_req_ready & b_req_valid});
      @(negedge clk);
    end
    chk("b.resp_count", resp_cnt, 6);
    chk("sb.empty", sb_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
